bcd_timer_ctrl: RTL and testbench

- Controller that sequences a cascade of DIGITS BCD decade counters as a start/stop preset timer.
- Supports count-down to zero and count-up to all-nines.
- Owns the per-digit enable/load/direction sequencing and ripple-carry gating, and raises done at the terminal value.
- Sits between the front-panel debounced strobes / 1 Hz prescaler and the display digit driver.

---
 rtl/bcd_timer_pkg.sv | 19 +
 rtl/bcd_digit.sv | 35 +++
 rtl/bcd_timer_ctrl.sv | 137 +++++++++++++
 tb/tb_bcd_timer_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_timer_pkg.sv
// Shared definitions for the BCD preset timer: FSM state encoding, BCD digit
// constants and the digit clamp helper.
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'h9;
    localparam logic [3:0] BCD_ZERO = 4'h0;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > BCD_NINE) ? BCD_NINE : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade counter with load, enable, direction and a combinational
// carry/borrow output that enables the next digit of the cascade.
module bcd_digit
    import bcd_timer_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic       ld,
    input  logic       up,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       co
);

    logic [3:0] q_reg;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q_reg <= BCD_ZERO;
        end else if (ld) begin
            q_reg <= bcd_clamp(d);
        end else if (en) begin
            if (up) begin
                q_reg <= (q_reg == BCD_NINE) ? BCD_ZERO : q_reg + 4'd1;
            end else begin
                q_reg <= (q_reg == BCD_ZERO) ? BCD_NINE : q_reg - 4'd1;
            end
        end
    end

    assign q  = q_reg;
    assign co = en & ((up & (q_reg == BCD_NINE)) | (~up & (q_reg == BCD_ZERO)));

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Start/stop preset timer controller: owns the run FSM and the count direction,
// and sequences a ripple-enabled cascade of bcd_digit counters.
module bcd_timer_ctrl
    import bcd_timer_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                tick,
    input  logic                start,
    input  logic                stop,
    input  logic                load,
    input  logic                up,
    input  logic [4*DIGITS-1:0] preset,
    output logic [4*DIGITS-1:0] count,
    output logic [1:0]          state,
    output logic                running,
    output logic                done
);

    localparam logic [DIGITS-1:0] LSB_MASK = DIGITS'(1);

    state_t state_reg;
    logic   dir_reg;
    logic   running_reg;
    logic   done_reg;

    logic [4*DIGITS-1:0] preset_cl;
    logic [DIGITS-1:0]   dig_en;
    logic [DIGITS-1:0]   dig_co;
    logic [DIGITS-1:0]   cnt_is0;
    logic [DIGITS-1:0]   cnt_is9;
    logic [DIGITS-1:0]   pre_is0;
    logic [DIGITS-1:0]   pre_is9;

    logic load_acc;
    logic step_en;
    logic eff_is0;
    logic eff_is9;
    logic start_term;
    logic step_term;
    logic wrap;

    assign load_acc = load & (state_reg != RUN);
    assign step_en  = tick & (state_reg == RUN) & ~stop;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign preset_cl[4*gi +: 4] = bcd_clamp(preset[4*gi +: 4]);
            assign cnt_is0[gi] = (count[4*gi +: 4] == BCD_ZERO);
            assign cnt_is9[gi] = (count[4*gi +: 4] == BCD_NINE);
            assign pre_is0[gi] = (preset_cl[4*gi +: 4] == BCD_ZERO);
            assign pre_is9[gi] = (preset_cl[4*gi +: 4] == BCD_NINE);

            if (gi == 0) begin : g_lsd
                assign dig_en[gi] = step_en;
            end else begin : g_hsd
                assign dig_en[gi] = dig_co[gi-1];
            end

            bcd_digit u_digit (
                .clk (clk),
                .clr (clr),
                .en  (dig_en[gi]),
                .ld  (load_acc),
                .up  (dir_reg),
                .d   (preset_cl[4*gi +: 4]),
                .q   (count[4*gi +: 4]),
                .co  (dig_co[gi])
            );
        end
    endgenerate

    // A start is judged against the count it would run from, which is the
    // clamped preset when a load lands on the same edge.
    assign eff_is0    = load_acc ? (&pre_is0) : (&cnt_is0);
    assign eff_is9    = load_acc ? (&pre_is9) : (&cnt_is9);
    assign start_term = up ? eff_is9 : eff_is0;

    // The step reaches the terminal value when the count is one short of it.
    assign step_term = dir_reg
        ? ((count[3:0] == 4'd8) & (&(cnt_is9 | LSB_MASK)))
        : ((count[3:0] == 4'd1) & (&(cnt_is0 | LSB_MASK)));

    // A carry out of the top digit would mean a wrap past the terminal value;
    // it is unreachable but still forces DONE rather than counting on.
    assign wrap = dig_co[DIGITS-1];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg   <= IDLE;
            dir_reg     <= 1'b0;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, PAUSE: begin
                    if (start && !start_term) begin
                        state_reg   <= RUN;
                        dir_reg     <= up;
                        running_reg <= 1'b1;
                        done_reg    <= 1'b0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_reg   <= PAUSE;
                        running_reg <= 1'b0;
                        done_reg    <= 1'b0;
                    end else if (step_en && (step_term || wrap)) begin
                        state_reg   <= DONE;
                        running_reg <= 1'b0;
                        done_reg    <= 1'b1;
                    end
                end
                DONE: begin
                    if (start || load) begin
                        state_reg   <= IDLE;
                        running_reg <= 1'b0;
                        done_reg    <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    running_reg <= 1'b0;
                    done_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign state   = state_reg;
    assign running = running_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Self-checking bench for bcd_timer_ctrl (DIGITS=4): directed scenarios plus a
// randomized phase, all checked against an integer-valued reference model.
module tb_bcd_timer_ctrl;

    localparam int D    = 4;
    localparam int MAXV = 9999;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          tick = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          load = 1'b0;
    logic          up = 1'b0;
    logic [4*D-1:0] preset = '0;
    logic [4*D-1:0] count;
    logic [1:0]    state;
    logic          running;
    logic          done;

    int checks = 0;
    int errors = 0;

    // Reference model: count as a plain decimal integer.
    int m_val   = 0;
    int m_state = 0;
    bit m_dir   = 1'b0;

    bcd_timer_ctrl #(.DIGITS(D)) dut (
        .clk     (clk),
        .clr     (clr),
        .tick    (tick),
        .start   (start),
        .stop    (stop),
        .load    (load),
        .up      (up),
        .preset  (preset),
        .count   (count),
        .state   (state),
        .running (running),
        .done    (done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int preset_value(input logic [15:0] p);
        int v;
        int w;
        int dg;
        v = 0;
        w = 1;
        for (int i = 0; i < D; i++) begin
            dg = int'(p[4*i +: 4]);
            if (dg > 9) dg = 9;
            v = v + dg * w;
            w = w * 10;
        end
        return v;
    endfunction

    task automatic model_update(input bit st, input bit sp, input bit ld, input bit tk,
                                input bit u, input logic [15:0] pre);
        int target;
        case (m_state)
            1: begin
                if (sp) begin
                    m_state = 2;
                end else if (tk) begin
                    m_val  = m_dir ? m_val + 1 : m_val - 1;
                    target = m_dir ? MAXV : 0;
                    if (m_val == target) m_state = 3;
                end
            end
            3: begin
                if (ld) m_val = preset_value(pre);
                if (st || ld) m_state = 0;
            end
            default: begin
                if (ld) m_val = preset_value(pre);
                target = u ? MAXV : 0;
                if (st && m_val != target) begin
                    m_state = 1;
                    m_dir   = u;
                end
            end
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_count"},   32'(count),   32'(to_bcd(m_val)));
        chk({tag, "_state"},   32'(state),   32'(m_state));
        chk({tag, "_running"}, 32'(running), 32'(m_state == 1));
        chk({tag, "_done"},    32'(done),    32'(m_state == 3));
    endtask

    task automatic step(input bit st, input bit sp, input bit ld, input bit tk,
                        input bit u, input logic [15:0] pre, input string tag);
        @(negedge clk);
        start  = st;
        stop   = sp;
        load   = ld;
        tick   = tk;
        up     = u;
        preset = pre;
        @(posedge clk);
        model_update(st, sp, ld, tk, u, pre);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        load  = 1'b0;
        tick  = 1'b0;
        chk_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 clr = 1'b0;
        #1;
        m_val   = 0;
        m_state = 0;
        m_dir   = 1'b0;
        chk("rst_count",   32'(count),   32'h0);
        chk("rst_state",   32'(state),   32'h0);
        chk("rst_done",    32'(done),    32'h0);
        chk("rst_running", 32'(running), 32'h0);
        @(negedge clk);
        clr = 1'b1;
    endtask

    initial begin
        logic [15:0] rp;
        bit rst_, rsp, rld, rtk, rup;

        repeat (2) @(posedge clk);
        #1;
        chk_all("por");
        @(negedge clk);
        clr = 1'b1;

        // Reset asserted mid-run clears everything before the next edge.
        step(0, 0, 1, 0, 0, 16'h0042, "mr_load");
        step(1, 0, 0, 0, 0, 16'h0042, "mr_start");
        step(0, 0, 0, 1, 0, 16'h0042, "mr_tick");
        chk("mr_41", 32'(count), 32'h0041);
        do_reset();

        // Start down from zero is refused.
        step(1, 0, 0, 0, 0, 16'h0000, "ign_start0");
        chk("ign_idle", 32'(state), 32'h0);

        // Countdown with borrow.
        step(0, 0, 1, 0, 0, 16'h0100, "cd_load");
        step(1, 0, 0, 0, 0, 16'h0100, "cd_start");
        step(0, 0, 0, 1, 0, 16'h0100, "cd_t1");
        chk("cd_99", 32'(count), 32'h0099);
        for (int i = 0; i < 98; i++) step(0, 0, 0, 1, 0, 16'h0100, "cd_run");
        chk("cd_01", 32'(count), 32'h0001);
        step(0, 0, 0, 1, 0, 16'h0100, "cd_last");
        chk("cd_done", 32'(done), 32'h1);
        chk("cd_zero", 32'(count), 32'h0000);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 16'h0100, "cd_hold");
        chk("cd_hold0", 32'(count), 32'h0000);
        step(1, 0, 0, 0, 0, 16'h0100, "cd_ack");

        // Count-up ripple and termination at all-nines.
        step(0, 0, 1, 0, 1, 16'h0999, "cu_load");
        step(1, 0, 0, 0, 1, 16'h0999, "cu_start");
        step(0, 0, 0, 1, 1, 16'h0999, "cu_t1");
        chk("cu_1000", 32'(count), 32'h1000);
        step(0, 1, 0, 0, 1, 16'h0999, "cu_stop");
        step(0, 0, 1, 0, 1, 16'h9998, "cu_load2");
        step(1, 0, 0, 0, 1, 16'h9998, "cu_start2");
        step(0, 0, 0, 1, 1, 16'h9998, "cu_t2");
        chk("cu_9999", 32'(count), 32'h9999);
        chk("cu_doneS", 32'(state), 32'h3);
        step(1, 0, 0, 0, 1, 16'h9998, "cu_ack");
        chk("cu_ackcnt", 32'(count), 32'h9999);
        chk("cu_idle", 32'(state), 32'h0);

        // Pause/resume, stop priority, ignored load and direction change.
        step(1, 0, 1, 0, 0, 16'h0050, "pr_ldst");
        step(0, 1, 0, 1, 0, 16'h0050, "pr_stoptick");
        chk("pr_50", 32'(count), 32'h0050);
        chk("pr_pause", 32'(state), 32'h2);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 16'h0050, "pr_ptick");
        chk("pr_hold", 32'(count), 32'h0050);
        step(1, 0, 0, 0, 0, 16'h0050, "pr_resume");
        step(0, 0, 0, 1, 1, 16'h0050, "pr_uptoggle");
        chk("pr_49", 32'(count), 32'h0049);
        step(0, 0, 1, 1, 0, 16'h1234, "pr_runload");
        chk("pr_48", 32'(count), 32'h0048);
        step(0, 1, 0, 0, 0, 16'h1234, "pr_stop");
        step(0, 0, 1, 0, 0, 16'h0001, "pr_ld1");
        step(1, 0, 0, 0, 0, 16'h0001, "pr_st1");
        step(0, 0, 0, 1, 0, 16'h0001, "pr_t1");
        step(1, 1, 0, 0, 0, 16'h0001, "pr_ack");

        // Clamp with simultaneous load+start.
        step(1, 0, 1, 0, 0, 16'hAF30, "cl_ldst");
        chk("cl_9930", 32'(count), 32'h9930);
        chk("cl_run", 32'(state), 32'h1);

        // Randomized phase; presets kept near the terminal values.
        for (int n = 0; n < 2500; n++) begin
            rst_ = ($urandom_range(0, 99) < 8);
            rsp  = ($urandom_range(0, 99) < 4);
            rld  = ($urandom_range(0, 99) < 5);
            rtk  = ($urandom_range(0, 99) < 75);
            rup  = 1'($urandom_range(0, 1));
            rp[3:0] = 4'($urandom_range(0, 15));
            rp[7:4] = 4'($urandom_range(0, 15));
            rp[15:8] = ($urandom_range(0, 1) == 1) ? 8'h99 : 8'h00;
            step(rst_, rsp, rld, rtk, rup, rp, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
